// File: rtl/bp_me_wormhole_pkg.sv
// Shared wormhole definitions: serializer FSM states, header field offsets and flit-count helpers.
package bp_me_wormhole_pkg;

  typedef enum logic [0:0] {
    e_ser_idle = 1'b0,
    e_ser_send = 1'b1
  } bp_me_wh_ser_state_e;

  // Header layout: cord occupies the LSBs, len follows immediately after it.
  localparam int unsigned bp_me_wh_cord_lsb_gp = 32'd0;

  function automatic int unsigned bp_me_wh_len_lsb_f(input int unsigned cord_width);
    return bp_me_wh_cord_lsb_gp + cord_width;
  endfunction

  function automatic int unsigned bp_me_wh_max_flits_f(input int unsigned packet_width,
                                                      input int unsigned flit_width);
    return (packet_width + flit_width - 32'd1) / flit_width;
  endfunction

  function automatic int unsigned bp_me_wh_cnt_width_f(input int unsigned max_flits);
    return (max_flits > 32'd1) ? $clog2(max_flits) : 32'd1;
  endfunction

endpackage

// File: rtl/bp_me_wormhole_flit_select.sv
// Combinational flit mux: returns flit idx_i of a padded packet, zero for out-of-range indices.
module bp_me_wormhole_flit_select
  import bp_me_wormhole_pkg::*;
  #(parameter int flit_width_p = 64,
    parameter int max_flits_lp = 9)
  (input  logic [flit_width_p*max_flits_lp-1:0]              data_i,
   input  logic [bp_me_wh_cnt_width_f(max_flits_lp)-1:0]     idx_i,
   output logic [flit_width_p-1:0]                           flit_o);

  localparam int idx_width_lp = bp_me_wh_cnt_width_f(max_flits_lp);

  // One-hot OR of the selected slice
  always_comb begin
    flit_o = '0;
    for (int i = 0; i < max_flits_lp; i++) begin
      flit_o |= (idx_i == idx_width_lp'(i)) ? data_i[i*flit_width_p +: flit_width_p]
                                            : {flit_width_p{1'b0}};
    end
  end

endmodule

// File: rtl/bp_me_wormhole_flit_serializer_lce_resp_chk.sv
// Simulation checker for the LCE response serializer: flags packets whose len exceeds the flit capacity.
module bp_me_wormhole_flit_serializer_lce_resp_chk
  #(parameter int len_width_p = 4,
    parameter int max_flits_p = 9)
  (input logic                   clk_i,
   input logic                   reset_i,
   input logic                   accept_i,
   input logic [len_width_p-1:0] raw_len_i);

  // Oversized len is clamped by the datapath; this only reports it
  always @(posedge clk_i) begin
    if (!reset_i && accept_i) begin
      assert (int'(raw_len_i) <= max_flits_p - 1)
        else $warning("serializer: packet len %0d exceeds %0d, clamped", raw_len_i, max_flits_p - 1);
    end
  end

endmodule

// File: rtl/bp_me_wormhole_flit_serializer_lce_resp.sv
// LCE->CCE response wormhole serializer: one packet in, len+1 flits out, no bubble between packets.
// Optional BP_ME_WH_SERIALIZER_STATS_EN adds saturating packet/flit counters.
module bp_me_wormhole_flit_serializer_lce_resp
  import bp_me_wormhole_pkg::*;
  #(parameter int flit_width_p   = 64,
    parameter int packet_width_p = 576,
    parameter int len_width_p    = 4,
    parameter int cord_width_p   = 8)
  (input  logic                      clk_i,
   input  logic                      reset_i,
   input  logic [packet_width_p-1:0] packet_i,
   input  logic                      packet_v_i,
   output logic                      packet_ready_o,
   output logic [flit_width_p-1:0]   link_data_o,
   output logic                      link_v_o,
   input  logic                      link_ready_i
`ifdef BP_ME_WH_SERIALIZER_STATS_EN
   ,output logic [31:0]              pkt_count_o
   ,output logic [31:0]              flit_count_o
`endif
   );

  localparam int max_flits_lp    = bp_me_wh_max_flits_f(packet_width_p, flit_width_p);
  localparam int padded_width_lp = max_flits_lp * flit_width_p;
  localparam int cnt_width_lp    = bp_me_wh_cnt_width_f(max_flits_lp);
  localparam int len_lsb_lp      = bp_me_wh_len_lsb_f(cord_width_p);

  bp_me_wh_ser_state_e         state_q, state_d;
  logic [padded_width_lp-1:0]  pkt_q, pkt_d;
  logic [cnt_width_lp-1:0]     len_q, len_d;
  logic [cnt_width_lp-1:0]     cnt_q, cnt_d;

  logic [padded_width_lp-1:0]  padded_s;
  logic [len_width_p-1:0]      raw_len_s;
  logic [cnt_width_lp-1:0]     eff_len_s;
  logic                        last_s;
  logic                        ready_s;
  logic                        accept_s;

  assign padded_s  = padded_width_lp'(packet_i);
  assign raw_len_s = packet_i[len_lsb_lp +: len_width_p];
  assign last_s    = (cnt_q == len_q);
  assign accept_s  = packet_v_i & ready_s;

  // Clamp len so the counter can never index past the last real flit
  always_comb begin
    eff_len_s = cnt_width_lp'(raw_len_s);
    if (int'(raw_len_s) > max_flits_lp - 1) begin
      eff_len_s = cnt_width_lp'(max_flits_lp - 1);
    end else begin
      eff_len_s = cnt_width_lp'(raw_len_s);
    end
  end

  // Next-state: a packet offered on the last-flit handshake is loaded in place, keeping SEND
  always_comb begin
    state_d = state_q;
    pkt_d   = pkt_q;
    len_d   = len_q;
    cnt_d   = cnt_q;
    ready_s = 1'b0;
    case (state_q)
      e_ser_idle: begin
        ready_s = 1'b1;
        if (packet_v_i) begin
          pkt_d   = padded_s;
          len_d   = eff_len_s;
          cnt_d   = '0;
          state_d = e_ser_send;
        end else begin
          state_d = e_ser_idle;
        end
      end
      e_ser_send: begin
        if (link_ready_i) begin
          if (last_s) begin
            ready_s = 1'b1;
            if (packet_v_i) begin
              pkt_d   = padded_s;
              len_d   = eff_len_s;
              cnt_d   = '0;
              state_d = e_ser_send;
            end else begin
              state_d = e_ser_idle;
            end
          end else begin
            cnt_d = cnt_q + cnt_width_lp'(1);
          end
        end else begin
          state_d = e_ser_send;
        end
      end
      default: begin
        state_d = e_ser_idle;
      end
    endcase
  end

  // State, packet, len and flit counter registers
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q <= e_ser_idle;
      pkt_q   <= '0;
      len_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      pkt_q   <= pkt_d;
      len_q   <= len_d;
      cnt_q   <= cnt_d;
    end
  end

  bp_me_wormhole_flit_select
    #(.flit_width_p(flit_width_p), .max_flits_lp(max_flits_lp))
    u_flit_select
     (.data_i(pkt_q), .idx_i(cnt_q), .flit_o(link_data_o));

  assign link_v_o       = (state_q == e_ser_send);
  assign packet_ready_o = ready_s;

  bp_me_wormhole_flit_serializer_lce_resp_chk
    #(.len_width_p(len_width_p), .max_flits_p(max_flits_lp))
    u_chk
     (.clk_i(clk_i), .reset_i(reset_i), .accept_i(accept_s), .raw_len_i(raw_len_s));

`ifdef BP_ME_WH_SERIALIZER_STATS_EN
  logic        handshake_s;
  logic [31:0] pkt_count_q;
  logic [31:0] flit_count_q;

  assign handshake_s = link_v_o & link_ready_i;

  // Saturating traffic counters
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      pkt_count_q  <= 32'd0;
      flit_count_q <= 32'd0;
    end else begin
      if (accept_s && (pkt_count_q != 32'hFFFF_FFFF)) begin
        pkt_count_q <= pkt_count_q + 32'd1;
      end
      if (handshake_s && (flit_count_q != 32'hFFFF_FFFF)) begin
        flit_count_q <= flit_count_q + 32'd1;
      end
    end
  end

  assign pkt_count_o  = pkt_count_q;
  assign flit_count_o = flit_count_q;
`endif

endmodule

// File: tb/tb_bp_me_wormhole_flit_serializer_lce_resp.sv
// Randomized bench for the LCE response serializer against a flit-queue reference model.
module tb_bp_me_wormhole_flit_serializer_lce_resp;

  localparam int FW = 64;
  localparam int PW = 576;
  localparam int MAXF = 9;

  logic          clk = 1'b0;
  logic          reset_i = 1'b1;
  logic [PW-1:0] packet_i = '0;
  logic          packet_v_i = 1'b0;
  logic          packet_ready_o;
  logic [FW-1:0] link_data_o;
  logic          link_v_o;
  logic          link_ready_i = 1'b0;
`ifdef BP_ME_WH_SERIALIZER_STATS_EN
  logic [31:0]   pkt_count_o;
  logic [31:0]   flit_count_o;
`endif

  bp_me_wormhole_flit_serializer_lce_resp dut (
    .clk_i(clk), .reset_i(reset_i), .packet_i(packet_i), .packet_v_i(packet_v_i),
    .packet_ready_o(packet_ready_o), .link_data_o(link_data_o), .link_v_o(link_v_o),
    .link_ready_i(link_ready_i)
`ifdef BP_ME_WH_SERIALIZER_STATS_EN
    , .pkt_count_o(pkt_count_o), .flit_count_o(flit_count_o)
`endif
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int m_pkts  = 0;
  int m_flits = 0;

  logic [PW-1:0] drv_q[$];   // packets waiting to be offered
  logic [FW-1:0] exp_q[$];   // flits the serializer still owes the link

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [PW-1:0] make_pkt(input int len);
    logic [PW-1:0] p;
    for (int i = 0; i < PW/32; i++) p[i*32 +: 32] = $urandom;
    p[11:8] = len[3:0];
    return p;
  endfunction

  task automatic push_flits(input logic [PW-1:0] p);
    int n;
    logic [PW-1:0] sh;
    n = int'(p[11:8]);
    if (n > MAXF - 1) n = MAXF - 1;
    for (int i = 0; i <= n; i++) begin
      sh = p >> (FW * i);
      exp_q.push_back(sh[FW-1:0]);
    end
  endtask

  task automatic tick(input logic lr, input logic rst);
    logic exp_ready;
    @(negedge clk);
    reset_i      = rst;
    link_ready_i = lr;
    packet_v_i   = !rst && (drv_q.size() != 0);
    packet_i     = (drv_q.size() != 0) ? drv_q[0] : '0;
    #1;
    if (rst) begin
      exp_q.delete();
      drv_q.delete();
      m_pkts  = 0;
      m_flits = 0;
    end else begin
      exp_ready = (exp_q.size() == 0) || (exp_q.size() == 1 && lr);
      check_val("link_v", 64'(link_v_o), 64'(exp_q.size() != 0));
      check_val("pkt_ready", 64'(packet_ready_o), 64'(exp_ready));
      if (exp_q.size() != 0) begin
        check_val("flit_data", link_data_o, exp_q[0]);
        if (lr) begin
          void'(exp_q.pop_front());
          m_flits++;
        end
      end
      if (packet_v_i && exp_ready) begin
        push_flits(drv_q.pop_front());
        m_pkts++;
      end
    end
  endtask

  task automatic drain(input int mode);
    int budget = 0;
    logic lr;
    while ((drv_q.size() != 0 || exp_q.size() != 0) && budget < 400) begin
      case (mode)
        0: lr = 1'b1;
        1: lr = (budget % 2 == 0);
        default: lr = 1'($urandom % 2);
      endcase
      tick(lr, 1'b0);
      budget++;
    end
    check_val("drain", 64'(drv_q.size() + exp_q.size()), 64'd0);
    tick(1'b1, 1'b0);
  endtask

  initial begin
    tick(1'b0, 1'b1);
    tick(1'b0, 1'b1);
    tick(1'b0, 1'b0);
    tick(1'b1, 1'b0);

    // len=1 single packet
    drv_q.push_back(make_pkt(1));
    drain(0);
    // two back-to-back len=1 packets
    drv_q.push_back(make_pkt(1));
    drv_q.push_back(make_pkt(1));
    drain(0);
`ifdef BP_ME_WH_SERIALIZER_STATS_EN
    check_val("pkt_count", 64'(pkt_count_o), 64'd3);
    check_val("flit_count", 64'(flit_count_o), 64'd6);
`endif

    // reset in the middle of a 9-flit packet
    drv_q.push_back(make_pkt(8));
    tick(1'b1, 1'b0);
    for (int i = 0; i < 3; i++) tick(1'b1, 1'b0);
    tick(1'b1, 1'b1);
    for (int i = 0; i < 5; i++) tick(1'b1, 1'b0);

    // len=8 with toggling ready, then oversized len, then len=0 pair
    drv_q.push_back(make_pkt(8));
    drain(1);
    drv_q.push_back(make_pkt(15));
    drain(0);
    drv_q.push_back(make_pkt(0));
    drv_q.push_back(make_pkt(0));
    drain(0);

    // random traffic
    for (int c = 0; c < 600; c++) begin
      if (($urandom % 3 == 0) && drv_q.size() < 2) drv_q.push_back(make_pkt(int'($urandom % 16)));
      tick(1'($urandom % 4 != 0), 1'b0);
    end
    drain(2);
`ifdef BP_ME_WH_SERIALIZER_STATS_EN
    check_val("pkt_count_rand", 64'(pkt_count_o), 64'(m_pkts));
    check_val("flit_count_rand", 64'(flit_count_o), 64'(m_flits));
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
